// File: rtl/adc_lane_merger.sv
// Merges NCH ADC lanes of SPB samples each into one sample-major interleaved beat,
// reducing IN_W-bit samples to OUT_W bits by truncation or saturating round-half-up.
module adc_lane_merger #(
    parameter int NCH        = 6,
    parameter int SPB        = 4,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int CNT_W      = 32,
    parameter int FLUSH_IDLE = 1
) (
    input  logic                       ps_clk,
    input  logic                       ps_rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       round_mode,
    input  logic [NCH-1:0]             ch_enable,
    input  logic [CNT_W-1:0]           cap_beats,
    input  logic [NCH-1:0]             s_axis_tvalid,
    output logic [NCH-1:0]             s_axis_tready,
    input  logic [NCH*SPB*IN_W-1:0]    s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [NCH*SPB*OUT_W-1:0]   m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       cap_done,
    output logic                       cfg_err,
    output logic [CNT_W-1:0]           beat_count,
    output logic [15:0]                sat_count
);

    localparam int SH = IN_W - OUT_W;
    localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(2 ** (SH - 1));
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic FLUSH = (FLUSH_IDLE != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                      state_q;
    logic                        round_q;
    logic [NCH-1:0]              en_q;
    logic [CNT_W-1:0]            capb_q;
    logic [CNT_W-1:0]            issued_q;
    logic [CNT_W-1:0]            beat_q;
    logic                        mvalid_q;
    logic                        mlast_q;
    logic [NCH*SPB*OUT_W-1:0]    mdata_q;
    logic                        cfg_err_q;
    logic [15:0]                 sat_q;

    logic                        lanes_ok;
    logic                        accept;
    logic                        last_d;
    logic [NCH*SPB*OUT_W-1:0]    data_d;
    logic [15:0]                 nclip;
    logic [16:0]                 sat_sum;
    logic [15:0]                 sat_d;
    logic [IN_W-1:0]             samp;
    logic signed [IN_W:0]        sum;
    logic signed [IN_W:0]        shr;
    logic                        clip;
    logic [OUT_W-1:0]            red;

    // Disabled lanes never gate the beat; their valid is a don't-care.
    always_comb begin
        lanes_ok = &(s_axis_tvalid | ~en_q);
        accept   = (state_q == ST_RUN) && lanes_ok && (!mvalid_q || m_axis_tready)
                   && (issued_q < capb_q);
        last_d   = (issued_q == capb_q - CNT_W'(1));
        for (int unsigned c = 0; c < NCH; c++) begin
            s_axis_tready[c] = (en_q[c] && state_q == ST_RUN) ? accept : FLUSH;
        end
    end

    always_comb begin
        data_d = '0;
        nclip  = '0;
        samp   = '0;
        sum    = '0;
        shr    = '0;
        clip   = 1'b0;
        red    = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned s = 0; s < SPB; s++) begin
                samp = s_axis_tdata[(c * SPB + s) * IN_W +: IN_W];
                sum  = {samp[IN_W-1], samp} + HALF;
                shr  = sum >>> SH;
                clip = round_q && en_q[c] && (shr > MAXV);
                if (!en_q[c]) begin
                    red = '0;
                end else if (!round_q) begin
                    red = samp[IN_W-1 -: OUT_W];
                end else if (clip) begin
                    red = MAXV[OUT_W-1:0];
                end else begin
                    red = shr[OUT_W-1:0];
                end
                data_d[(s * NCH + c) * OUT_W +: OUT_W] = red;
                if (clip) begin
                    nclip = nclip + 16'd1;
                end
            end
        end
        sat_sum = {1'b0, sat_q} + {1'b0, nclip};
        sat_d   = sat_sum[16] ? '1 : sat_sum[15:0];
    end

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            state_q   <= ST_IDLE;
            round_q   <= 1'b0;
            en_q      <= '0;
            capb_q    <= '0;
            issued_q  <= '0;
            beat_q    <= '0;
            mvalid_q  <= 1'b0;
            mlast_q   <= 1'b0;
            mdata_q   <= '0;
            cfg_err_q <= 1'b0;
            sat_q     <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (abort) begin
                state_q  <= ST_IDLE;
                mvalid_q <= 1'b0;
                mlast_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (cap_beats != '0 && ch_enable != '0) begin
                                state_q  <= ST_RUN;
                                round_q  <= round_mode;
                                en_q     <= ch_enable;
                                capb_q   <= cap_beats;
                                issued_q <= '0;
                                beat_q   <= '0;
                                sat_q    <= '0;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (mvalid_q && m_axis_tready) begin
                            beat_q <= beat_q + CNT_W'(1);
                            if (mlast_q) begin
                                state_q <= ST_DONE;
                            end
                        end
                        // Output register only reloads on accept, so data holds during a stall.
                        if (accept) begin
                            mvalid_q <= 1'b1;
                            mdata_q  <= data_d;
                            mlast_q  <= last_d;
                            issued_q <= issued_q + CNT_W'(1);
                            sat_q    <= sat_d;
                        end else if (m_axis_tready) begin
                            mvalid_q <= 1'b0;
                            mlast_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tlast  = mlast_q;
    assign busy          = (state_q == ST_RUN);
    assign cap_done      = (state_q == ST_DONE);
    assign cfg_err       = cfg_err_q;
    assign beat_count    = beat_q;
    assign sat_count     = sat_q;

endmodule

// File: tb/tb_adc_lane_merger.sv
// Directed bench for adc_lane_merger at default parameters (6 lanes, 4 samples, 16->8 bits).
module tb_adc_lane_merger;

    localparam int NCH = 6;
    localparam int SPB = 4;
    localparam int IW  = NCH * SPB * 16;
    localparam int OWD = NCH * SPB * 8;

    logic            ps_clk = 1'b0;
    logic            ps_rst;
    logic            start;
    logic            abort;
    logic            round_mode;
    logic [NCH-1:0]  ch_enable;
    logic [31:0]     cap_beats;
    logic [NCH-1:0]  s_axis_tvalid;
    logic [NCH-1:0]  s_axis_tready;
    logic [IW-1:0]   s_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [OWD-1:0]  m_axis_tdata;
    logic            m_axis_tlast;
    logic            busy;
    logic            cap_done;
    logic            cfg_err;
    logic [31:0]     beat_count;
    logic [15:0]     sat_count;

    int checks = 0;
    int errors = 0;

    adc_lane_merger #(
        .NCH(6), .SPB(4), .IN_W(16), .OUT_W(8), .CNT_W(32), .FLUSH_IDLE(1)
    ) dut (
        .ps_clk(ps_clk), .ps_rst(ps_rst), .start(start), .abort(abort),
        .round_mode(round_mode), .ch_enable(ch_enable), .cap_beats(cap_beats),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .cap_done(cap_done),
        .cfg_err(cfg_err), .beat_count(beat_count), .sat_count(sat_count)
    );

    always #5 ps_clk = ~ps_clk;

    // Lane c sample s of beat b: upper byte 16*b + 4*c + s, lower byte 0xA5.
    function automatic logic [IW-1:0] mk_beat(input int b);
        logic [IW-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < SPB; s++)
                v[(c * SPB + s) * 16 +: 16] = {8'(16 * b + c * SPB + s), 8'hA5};
        return v;
    endfunction

    // Expected merged beat; add is 1 when rounding (0xA5 low byte carries up).
    function automatic logic [OWD-1:0] exp_beat(input int b, input logic [NCH-1:0] en, input int add);
        logic [OWD-1:0] o;
        o = '0;
        for (int s = 0; s < SPB; s++)
            for (int c = 0; c < NCH; c++)
                o[(s * NCH + c) * 8 +: 8] = en[c] ? 8'(16 * b + c * SPB + s + add) : 8'h00;
        return o;
    endfunction

    task automatic tick;
        @(posedge ps_clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] cb, input logic [NCH-1:0] en, input logic rnd);
        cap_beats  = cb;
        ch_enable  = en;
        round_mode = rnd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset;
        ps_rst = 1'b1;
        tick();
        tick();
        ps_rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (cap_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", cap_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b exp 0", cfg_err); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
        checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL rst_beat_count got %0d exp 0", beat_count); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat_count got %0d exp 0", sat_count); end
        checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL rst_tready got %b exp 111111", s_axis_tready); end
    endtask

    task automatic test_cfg_err;
        do_start(32'd0, 6'h3F, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_zero_beats got %b exp 1", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfgerr_busy got %b exp 0", busy); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgerr_pulse_len got %b exp 0", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfgerr_busy2 got %b exp 0", busy); end
        do_start(32'd4, 6'h00, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_no_lanes got %b exp 1", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfgerr_busy3 got %b exp 0", busy); end
        tick();
    endtask

    task automatic test_basic;
        do_start(32'd4, 6'h3F, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        s_axis_tvalid = 6'h3F;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_axis_tdata = mk_beat(b);
            // Mid-run start and config changes must be ignored.
            if (b == 1) begin
                start = 1'b1; cap_beats = 32'd2; round_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL basic_tready b%0d got %b exp 111111", b, s_axis_tready); end
            tick();
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid b%0d got %b exp 1", b, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_beat(b, 6'h3F, 0)) begin errors++; $display("FAIL basic_tdata b%0d got %h exp %h", b, m_axis_tdata, exp_beat(b, 6'h3F, 0)); end
            checks++; if (m_axis_tlast !== (b == 3)) begin errors++; $display("FAIL basic_tlast b%0d got %b exp %b", b, m_axis_tlast, (b == 3)); end
            checks++; if (beat_count !== 32'(b)) begin errors++; $display("FAIL basic_beat_count b%0d got %0d exp %0d", b, beat_count, b); end
        end
        start = 1'b0;
        #1;
        checks++; if (s_axis_tready !== 6'h00) begin errors++; $display("FAIL basic_tready_full got %b exp 000000", s_axis_tready); end
        tick();
        checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL basic_cap_done got %b exp 1", cap_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_end got %b exp 0", m_axis_tvalid); end
        checks++; if (beat_count !== 32'd4) begin errors++; $display("FAIL basic_beat_count_end got %0d exp 4", beat_count); end
        checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL basic_tready_done got %b exp 111111", s_axis_tready); end
        round_mode = 1'b0;
        s_axis_tvalid = '0;
    endtask

    task automatic test_round;
        logic [OWD-1:0] ex;
        do_start(32'd1, 6'h3F, 1'b1);
        s_axis_tdata = '0;
        s_axis_tdata[0 * 64 +: 16] = 16'h7FF0;
        s_axis_tdata[1 * 64 +: 16] = 16'h0080;
        s_axis_tdata[2 * 64 +: 16] = 16'hFF7F;
        s_axis_tdata[3 * 64 +: 16] = 16'h8000;
        s_axis_tvalid = 6'h3F;
        m_axis_tready = 1'b1;
        ex = '0;
        ex[7:0]   = 8'h7F;
        ex[15:8]  = 8'h01;
        ex[23:16] = 8'hFF;
        ex[31:24] = 8'h80;
        tick();
        s_axis_tvalid = '0;
        checks++; if (m_axis_tdata !== ex) begin errors++; $display("FAIL round_tdata got %h exp %h", m_axis_tdata, ex); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL round_tlast got %b exp 1", m_axis_tlast); end
        checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL round_sat_count got %0d exp 1", sat_count); end
        tick();
        checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL round_cap_done got %b exp 1", cap_done); end
        checks++; if (beat_count !== 32'd1) begin errors++; $display("FAIL round_beat_count got %0d exp 1", beat_count); end
    endtask

    task automatic test_disabled;
        logic [IW-1:0] d;
        do_start(32'd2, 6'b000101, 1'b1);
        s_axis_tvalid = 6'b111101;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            d = mk_beat(b);
            d[64 +: 64] = {4{16'h7FFF}};
            s_axis_tdata = d;
            #1;
            checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL dis_tready b%0d got %b exp 111111", b, s_axis_tready); end
            tick();
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL dis_tvalid b%0d got %b exp 1", b, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_beat(b, 6'b000101, 1)) begin errors++; $display("FAIL dis_tdata b%0d got %h exp %h", b, m_axis_tdata, exp_beat(b, 6'b000101, 1)); end
        end
        tick();
        checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL dis_cap_done got %b exp 1", cap_done); end
        checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL dis_beat_count got %0d exp 2", beat_count); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL dis_sat_count got %0d exp 0", sat_count); end
        s_axis_tvalid = '0;
    endtask

    task automatic test_backpressure;
        do_start(32'd3, 6'h3F, 1'b0);
        s_axis_tvalid = 6'h3F;
        m_axis_tready = 1'b1;
        s_axis_tdata = mk_beat(0);
        tick();
        checks++; if (m_axis_tdata !== exp_beat(0, 6'h3F, 0)) begin errors++; $display("FAIL bp_b0 got %h exp %h", m_axis_tdata, exp_beat(0, 6'h3F, 0)); end
        s_axis_tdata = mk_beat(1);
        tick();
        checks++; if (m_axis_tdata !== exp_beat(1, 6'h3F, 0)) begin errors++; $display("FAIL bp_b1 got %h exp %h", m_axis_tdata, exp_beat(1, 6'h3F, 0)); end
        s_axis_tdata = mk_beat(2);
        for (int k = 0; k < 2; k++) begin
            m_axis_tready = 1'b0;
            #1;
            checks++; if (s_axis_tready !== 6'h00) begin errors++; $display("FAIL bp_tready_stall k%0d got %b exp 000000", k, s_axis_tready); end
            tick();
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(1, 6'h3F, 0)) begin errors++; $display("FAIL bp_hold k%0d got v=%b %h exp v=1 %h", k, m_axis_tvalid, m_axis_tdata, exp_beat(1, 6'h3F, 0)); end
            checks++; if (beat_count !== 32'd1) begin errors++; $display("FAIL bp_beat_count_stall k%0d got %0d exp 1", k, beat_count); end
        end
        m_axis_tready = 1'b1;
        #1;
        checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL bp_tready_resume got %b exp 111111", s_axis_tready); end
        tick();
        checks++; if (m_axis_tdata !== exp_beat(2, 6'h3F, 0) || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL bp_b2 got %h last=%b exp %h last=1", m_axis_tdata, m_axis_tlast, exp_beat(2, 6'h3F, 0)); end
        checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL bp_beat_count got %0d exp 2", beat_count); end
        tick();
        checks++; if (cap_done !== 1'b1 || beat_count !== 32'd3) begin errors++; $display("FAIL bp_end got done=%b count=%0d exp done=1 count=3", cap_done, beat_count); end
        s_axis_tvalid = '0;
    endtask

    task automatic test_abort;
        do_start(32'd8, 6'h3F, 1'b0);
        s_axis_tvalid = 6'h3F;
        m_axis_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_axis_tdata = mk_beat(b);
            tick();
        end
        checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL abort_pre_count got %0d exp 2", beat_count); end
        abort = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || cap_done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b exp 0 0", busy, cap_done); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL abort_tlast got %b exp 0", m_axis_tlast); end
        checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL abort_count got %0d exp 2", beat_count); end
        checks++; if (s_axis_tready !== 6'h3F) begin errors++; $display("FAIL abort_drain got %b exp 111111", s_axis_tready); end
        m_axis_tready = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid2 got %b exp 0", m_axis_tvalid); end
        cap_beats = 32'd4; ch_enable = 6'h3F; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins got busy=%b exp 0", busy); end
        s_axis_tvalid = '0;
    endtask

    task automatic test_reset_midrun;
        do_start(32'd4, 6'h3F, 1'b0);
        s_axis_tvalid = 6'h3F;
        s_axis_tdata = mk_beat(0);
        m_axis_tready = 1'b0;
        tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", m_axis_tvalid); end
        ps_rst = 1'b1;
        tick();
        ps_rst = 1'b0;
        m_axis_tready = 1'b1;
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_out got v=%b l=%b exp 0 0", m_axis_tvalid, m_axis_tlast); end
        checks++; if (busy !== 1'b0 || m_axis_tdata !== '0) begin errors++; $display("FAIL rstmid_state got busy=%b data=%h exp 0 0", busy, m_axis_tdata); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid2 got %b exp 0", m_axis_tvalid); end
        s_axis_tvalid = '0;
    endtask

    initial begin
        ps_rst = 1'b1; start = 1'b0; abort = 1'b0; round_mode = 1'b0;
        ch_enable = '0; cap_beats = '0; s_axis_tvalid = '0; s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_cfg_err();
        test_basic();
        test_round();
        test_disabled();
        test_backpressure();
        test_abort();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_lane_merger.md
ADC_LANE_MERGER -- requirements
Module: adc_lane_merger

Interface
REQ-001 SHALL have parameter NCH, default 6: number of ADC lanes, legal 1..8.
REQ-002 SHALL have parameter SPB, default 4: samples per lane beat.
REQ-003 SHALL have parameters IN_W, default 16, and OUT_W, default 8: signed sample widths, IN_W > OUT_W.
REQ-004 SHALL have parameter CNT_W, default 32: beat-counter width.
REQ-005 SHALL have parameter FLUSH_IDLE, default 1: drain inputs when not running.
REQ-006 SHALL use one clock, ps_clk; reset ps_rst is synchronous and active-high.
REQ-007 Ports (name direction width meaning):
 ps_clk  in  1  clock
 ps_rst  in  1  sync active-high reset
 start  in  1  capture start pulse
 abort  in  1  capture abort pulse
 round_mode  in  1  0 truncate, 1 round-half-up saturating
 ch_enable  in  NCH  lane enable mask
 cap_beats  in  CNT_W  output beats per capture
 s_axis_tvalid  in  NCH  per-lane valid
 s_axis_tready  out  NCH  per-lane ready
 s_axis_tdata  in  NCH*SPB*IN_W  lane c at [c*SPB*IN_W +: SPB*IN_W], sample s at [s*IN_W +: IN_W]
 m_axis_tvalid  out  1  output valid
 m_axis_tready  in  1  output ready
 m_axis_tdata  out  NCH*SPB*OUT_W  merged, reduced samples
 m_axis_tlast  out  1  last beat of capture
 busy  out  1  state RUN
 cap_done  out  1  state DONE
 cfg_err  out  1  one-cycle pulse, start rejected
 beat_count  out  CNT_W  beats emitted this capture
 sat_count  out  16  samples clipped this capture, saturating at 65535

Function
REQ-008 States IDLE, RUN, DONE; reset state IDLE.
REQ-009 IDLE/DONE + start, latched cap_beats != 0 and ch_enable != 0 -> RUN; beat_count, sat_count cleared; round_mode, ch_enable, cap_beats latched.
REQ-010 start with cap_beats == 0 or ch_enable == 0 -> state unchanged, cfg_err pulses 1 cycle.
REQ-011 start while RUN ignored; mid-run changes to round_mode/ch_enable/cap_beats ignored.
REQ-012 abort in any state -> IDLE next cycle, m_axis_tvalid cleared (pending beat discarded), beat_count/sat_count held; abort wins over simultaneous start.
REQ-013 accept = RUN && all enabled lanes valid && (!m_axis_tvalid || m_axis_tready) && issued < latched cap_beats.
REQ-014 Enabled lane tready = accept in RUN, FLUSH_IDLE in IDLE/DONE; disabled lane tready = FLUSH_IDLE in all states; no combinational path from s_axis_tvalid of one lane to its own tready except via accept.
REQ-015 Latency 1 cycle: accepted beat appears on m_axis_* next cycle; full throughput, one beat per cycle under continuous valid/ready.
REQ-016 m_axis_tdata/tlast SHALL be stable while m_axis_tvalid && !m_axis_tready.
REQ-017 Output byte index j = s*NCH + c holds reduced lane c sample s (sample-major interleave); disabled lanes output 0.
REQ-018 Truncate: out = in[IN_W-1 -: OUT_W].
REQ-019 Round: sum = in + 2^(IN_W-OUT_W-1) in IN_W+1 bits, shift right IN_W-OUT_W; result > 2^(OUT_W-1)-1 -> clip to max, sat_count +1 per clipped sample (enabled lanes only).
REQ-020 m_axis_tlast = 1 only on beat number cap_beats; beat_count increments on each output handshake.
REQ-021 Handshake of tlast beat -> DONE; cap_done = 1 in DONE until next start or abort.
REQ-022 beat_count SHALL not wrap; cap_beats bounds it.

Reset
REQ-023 ps_rst -> IDLE; m_axis_tvalid, m_axis_tlast, busy, cap_done, cfg_err = 0; m_axis_tdata, beat_count, sat_count = 0; latched config = 0.
REQ-024 ps_rst mid-capture SHALL discard pending output beat with no tlast emitted.

Verification
REQ-025 NCH=6, all enabled, cap_beats=4, continuous valid/ready, truncate -> 4 beats on consecutive cycles after 1-cycle latency, tlast on 4th, cap_done=1, beat_count=4.
REQ-026 Round mode, lane 0 sample 0 = 0x7FF0, lane 1 sample 0 = 0x0080 -> output byte 0 = 0x7F, byte 1 = 0x01, sat_count=1.
REQ-027 ch_enable=6'b000101, lane 1 valid held 0 -> beats still emitted, bytes for lanes 1,3,4,5 = 0, lane 1 tready = 1.
REQ-028 m_axis_tready toggled 1,0,0,1 mid-capture -> tdata stable during stall, no beat lost or duplicated, inputs back-pressured.
REQ-029 start with cap_beats=0 -> cfg_err 1-cycle pulse, busy stays 0.
REQ-030 abort after 2 of 8 beats -> IDLE next cycle, m_axis_tvalid=0, beat_count=2, no tlast; inputs drained when FLUSH_IDLE=1.
